// File: rtl/coproc_pipe_if.sv
// Instruction issue, result retire and debug-read signals of the coprocessor pipeline.
interface coproc_pipe_if #(
  parameter int unsigned DATA_W = 6,
  parameter int unsigned ADDR_W = 4
);
  logic              in_valid;
  logic [3:0]        cmd_id;
  logic [ADDR_W-1:0] op0_id;
  logic [ADDR_W-1:0] op1_id;
  logic [ADDR_W-1:0] dst_id;

  logic              res_valid;
  logic [DATA_W-1:0] res_data;
  logic [ADDR_W-1:0] res_dst;
  logic              res_zero;
  logic              res_carry;
  logic              res_illegal;

  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_data;

  modport master (
    output in_valid, cmd_id, op0_id, op1_id, dst_id, dbg_addr,
    input  res_valid, res_data, res_dst, res_zero, res_carry, res_illegal, dbg_data
  );

  modport slave (
    input  in_valid, cmd_id, op0_id, op1_id, dst_id, dbg_addr,
    output res_valid, res_data, res_dst, res_zero, res_carry, res_illegal, dbg_data
  );
endinterface

// File: rtl/coproc_pipe.sv
// Four-stage coprocessor: S1 latch, S2 regfile read, S3 ALU, S4 result/writeback.
// Optional saturation and a full write-back bypass keep the pipe stall-free.
module coproc_pipe #(
  parameter int unsigned DATA_W = 6,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned SAT    = 0,
  parameter int unsigned FWD    = 1
) (
  input  logic          clk,
  input  logic          reset,
  coproc_pipe_if.slave  bus
);
  localparam int unsigned XW    = DATA_W + 1;
  localparam int unsigned DEPTH = 1 << ADDR_W;

  localparam logic [3:0] CMD_INC  = 4'd0;
  localparam logic [3:0] CMD_DEC  = 4'd1;
  localparam logic [3:0] CMD_NOT  = 4'd2;
  localparam logic [3:0] CMD_RAND = 4'd3;
  localparam logic [3:0] CMD_ROR  = 4'd4;
  localparam logic [3:0] CMD_ADD  = 4'd5;
  localparam logic [3:0] CMD_SUB  = 4'd6;
  localparam logic [3:0] CMD_AND  = 4'd7;
  localparam logic [3:0] CMD_OR   = 4'd8;
  localparam logic [3:0] CMD_XOR  = 4'd9;
  localparam logic [3:0] CMD_SHL  = 4'd10;
  localparam logic [3:0] CMD_SHR  = 4'd11;
  localparam logic [3:0] CMD_PASS = 4'd12;

  logic              v_s1_q, v_s1_d;
  logic [3:0]        cmd_s1_q, cmd_s1_d;
  logic [ADDR_W-1:0] src0_s1_q, src0_s1_d, src1_s1_q, src1_s1_d, dst_s1_q, dst_s1_d;

  logic              v_s3_q, v_s3_d;
  logic [3:0]        cmd_s3_q, cmd_s3_d;
  logic [ADDR_W-1:0] src0_s3_q, src0_s3_d, src1_s3_q, src1_s3_d, dst_s3_q, dst_s3_d;
  logic [DATA_W-1:0] opa_s3_q, opa_s3_d, opb_s3_q, opb_s3_d;

  logic              res_valid_q, res_valid_d;
  logic [DATA_W-1:0] res_data_q, res_data_d;
  logic [ADDR_W-1:0] res_dst_q, res_dst_d;
  logic              res_zero_q, res_zero_d;
  logic              res_carry_q, res_carry_d;
  logic              res_illegal_q, res_illegal_d;

  logic [DATA_W-1:0] rf_q [DEPTH];
  logic [DATA_W-1:0] rf_d [DEPTH];

  logic              wb_en;
  logic              fwd_en;
  logic [DATA_W-1:0] rd0, rd1, op_a, op_b, alu_data;
  logic [XW-1:0]     wide;
  logic              alu_carry, alu_illegal, arith, is_sub;

  // S4 is the only bypass source: anything older has already been written back.
  always_comb begin
    wb_en  = res_valid_q && !res_illegal_q;
    fwd_en = (FWD != 0) && wb_en;
    rd0    = (fwd_en && (res_dst_q == src0_s1_q)) ? res_data_q : rf_q[src0_s1_q];
    rd1    = (fwd_en && (res_dst_q == src1_s1_q)) ? res_data_q : rf_q[src1_s1_q];
    op_a   = (fwd_en && (res_dst_q == src0_s3_q)) ? res_data_q : opa_s3_q;
    op_b   = (fwd_en && (res_dst_q == src1_s3_q)) ? res_data_q : opb_s3_q;
  end

  // ALU; arithmetic runs one bit wider so the top bit is carry/borrow.
  always_comb begin
    wide        = '0;
    alu_data    = '0;
    alu_carry   = 1'b0;
    alu_illegal = 1'b0;
    arith       = 1'b0;
    is_sub      = 1'b0;
    case (cmd_s3_q)
      CMD_INC:  begin wide = XW'(op_b) + XW'(1);    arith = 1'b1; end
      CMD_DEC:  begin wide = XW'(op_b) - XW'(1);    arith = 1'b1; is_sub = 1'b1; end
      CMD_ADD:  begin wide = XW'(op_a) + XW'(op_b); arith = 1'b1; end
      CMD_SUB:  begin wide = XW'(op_a) - XW'(op_b); arith = 1'b1; is_sub = 1'b1; end
      CMD_NOT:  alu_data = ~op_b;
      CMD_RAND: alu_data = DATA_W'(&op_b);
      CMD_ROR:  alu_data = DATA_W'(|op_b);
      CMD_AND:  alu_data = op_a & op_b;
      CMD_OR:   alu_data = op_a | op_b;
      CMD_XOR:  alu_data = op_a ^ op_b;
      CMD_SHL:  begin alu_data = op_b << 1; alu_carry = op_b[DATA_W-1]; end
      CMD_SHR:  begin alu_data = op_b >> 1; alu_carry = op_b[0]; end
      CMD_PASS: alu_data = op_a;
      default:  alu_illegal = 1'b1;
    endcase
    if (arith) begin
      if ((SAT != 0) && wide[DATA_W]) begin
        alu_data  = is_sub ? '0 : '1;
        alu_carry = 1'b1;
      end else begin
        alu_data  = wide[DATA_W-1:0];
        alu_carry = wide[DATA_W];
      end
    end
  end

  always_comb begin
    v_s1_d    = bus.in_valid;
    cmd_s1_d  = bus.in_valid ? bus.cmd_id : cmd_s1_q;
    src0_s1_d = bus.in_valid ? bus.op0_id : src0_s1_q;
    src1_s1_d = bus.in_valid ? bus.op1_id : src1_s1_q;
    dst_s1_d  = bus.in_valid ? bus.dst_id : dst_s1_q;

    v_s3_d    = v_s1_q;
    cmd_s3_d  = v_s1_q ? cmd_s1_q  : cmd_s3_q;
    src0_s3_d = v_s1_q ? src0_s1_q : src0_s3_q;
    src1_s3_d = v_s1_q ? src1_s1_q : src1_s3_q;
    dst_s3_d  = v_s1_q ? dst_s1_q  : dst_s3_q;
    opa_s3_d  = v_s1_q ? rd0       : opa_s3_q;
    opb_s3_d  = v_s1_q ? rd1       : opb_s3_q;

    // Result fields hold their last values through bubbles.
    res_valid_d   = v_s3_q;
    res_data_d    = v_s3_q ? alu_data            : res_data_q;
    res_dst_d     = v_s3_q ? dst_s3_q            : res_dst_q;
    res_zero_d    = v_s3_q ? (alu_data == '0)    : res_zero_q;
    res_carry_d   = v_s3_q ? alu_carry           : res_carry_q;
    res_illegal_d = v_s3_q ? alu_illegal         : res_illegal_q;

    rf_d = rf_q;
    if (wb_en) rf_d[res_dst_q] = res_data_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      v_s1_q        <= 1'b0;
      cmd_s1_q      <= '0;
      src0_s1_q     <= '0;
      src1_s1_q     <= '0;
      dst_s1_q      <= '0;
      v_s3_q        <= 1'b0;
      cmd_s3_q      <= '0;
      src0_s3_q     <= '0;
      src1_s3_q     <= '0;
      dst_s3_q      <= '0;
      opa_s3_q      <= '0;
      opb_s3_q      <= '0;
      res_valid_q   <= 1'b0;
      res_data_q    <= '0;
      res_dst_q     <= '0;
      res_zero_q    <= 1'b0;
      res_carry_q   <= 1'b0;
      res_illegal_q <= 1'b0;
      rf_q          <= '{default: '0};
    end else begin
      v_s1_q        <= v_s1_d;
      cmd_s1_q      <= cmd_s1_d;
      src0_s1_q     <= src0_s1_d;
      src1_s1_q     <= src1_s1_d;
      dst_s1_q      <= dst_s1_d;
      v_s3_q        <= v_s3_d;
      cmd_s3_q      <= cmd_s3_d;
      src0_s3_q     <= src0_s3_d;
      src1_s3_q     <= src1_s3_d;
      dst_s3_q      <= dst_s3_d;
      opa_s3_q      <= opa_s3_d;
      opb_s3_q      <= opb_s3_d;
      res_valid_q   <= res_valid_d;
      res_data_q    <= res_data_d;
      res_dst_q     <= res_dst_d;
      res_zero_q    <= res_zero_d;
      res_carry_q   <= res_carry_d;
      res_illegal_q <= res_illegal_d;
      rf_q          <= rf_d;
    end
  end

  assign bus.res_valid   = res_valid_q;
  assign bus.res_data    = res_data_q;
  assign bus.res_dst     = res_dst_q;
  assign bus.res_zero    = res_zero_q;
  assign bus.res_carry   = res_carry_q;
  assign bus.res_illegal = res_illegal_q;
  assign bus.dbg_data    = rf_q[bus.dbg_addr];
endmodule

// File: tb/tb_coproc_pipe.sv
// Bench for coproc_pipe: two instances (wrap+bypass, saturate+no-bypass) share one stimulus
// stream; an architectural model fills per-instance scoreboards that negedge monitors drain.
module tb_coproc_pipe;
  localparam int unsigned DW   = 6;
  localparam int unsigned AW   = 4;
  localparam int unsigned NREG = 16;
  localparam int          MAXV = 63;

  typedef struct { int due; logic [12:0] v; } exp_t;
  typedef struct { int slot; int dst; int val; } wr_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  exp_t q_a[$];
  exp_t q_b[$];
  wr_t  pend_b[$];
  int   regs_a [NREG];
  int   regs_b [NREG];

  coproc_pipe_if #(.DATA_W(DW), .ADDR_W(AW)) bus_a ();
  coproc_pipe_if #(.DATA_W(DW), .ADDR_W(AW)) bus_b ();

  coproc_pipe #(.DATA_W(DW), .ADDR_W(AW), .SAT(0), .FWD(1)) dut_a (.clk(clk), .reset(reset), .bus(bus_a));
  coproc_pipe #(.DATA_W(DW), .ADDR_W(AW), .SAT(1), .FWD(0)) dut_b (.clk(clk), .reset(reset), .bus(bus_b));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: actual=0x%0h required=0x%0h", nm, cyc, act, exp);
    end
  endfunction

  // Reference: {dst, data, zero, carry, illegal} from plain integer arithmetic.
  function automatic logic [12:0] model(input int cmd, input int a, input int b, input int dst, input bit sat);
    int r = 0, data = 0, carry = 0, ill = 0;
    bit arith = 0;
    case (cmd)
      0:  begin r = b + 1; arith = 1; end
      1:  begin r = b - 1; arith = 1; end
      5:  begin r = a + b; arith = 1; end
      6:  begin r = a - b; arith = 1; end
      2:  data = MAXV - b;
      3:  data = (b == MAXV) ? 1 : 0;
      4:  data = (b != 0) ? 1 : 0;
      7:  data = a & b;
      8:  data = a | b;
      9:  data = a ^ b;
      10: begin data = (b * 2) % (MAXV + 1); carry = (b >= 32) ? 1 : 0; end
      11: begin data = b / 2; carry = b % 2; end
      12: data = a;
      default: ill = 1;
    endcase
    if (arith) begin
      if (r > MAXV)   begin data = sat ? MAXV : r - (MAXV + 1); carry = 1; end
      else if (r < 0) begin data = sat ? 0 : r + MAXV + 1;     carry = 1; end
      else data = r;
    end
    return {4'(dst), 6'(data), 1'(data == 0), 1'(carry), 1'(ill)};
  endfunction

  // Without bypass an instruction only sees results retired at least three slots earlier.
  function automatic void apply_b(input int lim);
    while (pend_b.size() > 0 && pend_b[0].slot <= lim) begin
      regs_b[pend_b[0].dst] = pend_b[0].val;
      void'(pend_b.pop_front());
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input bit v, input int cmd, input int a, input int b, input int d);
    bus_a.in_valid = v;         bus_b.in_valid = v;
    bus_a.cmd_id   = 4'(cmd);   bus_b.cmd_id   = 4'(cmd);
    bus_a.op0_id   = AW'(a);    bus_b.op0_id   = AW'(a);
    bus_a.op1_id   = AW'(b);    bus_b.op1_id   = AW'(b);
    bus_a.dst_id   = AW'(d);    bus_b.dst_id   = AW'(d);
  endtask

  task automatic issue(input int cmd, input int a, input int b, input int d);
    exp_t x;
    logic [12:0] e;
    set_in(1'b1, cmd, a, b, d);
    e = model(cmd, regs_a[a], regs_a[b], d, 1'b0);
    x.due = cyc + 3; x.v = e; q_a.push_back(x);
    if (cmd < 13) regs_a[d] = int'(e[8:3]);
    apply_b(cyc - 3);
    e = model(cmd, regs_b[a], regs_b[b], d, 1'b1);
    x.v = e; q_b.push_back(x);
    if (cmd < 13) pend_b.push_back('{cyc, d, int'(e[8:3])});
    tick();
    set_in(1'b0, 0, 0, 0, 0);
  endtask

  task automatic idle(input int n);
    set_in(1'b0, 0, 0, 0, 0);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Results already in S4 still show this cycle; younger ones die at the reset edge.
  task automatic do_reset();
    while (q_a.size() > 0 && q_a[$].due > cyc) void'(q_a.pop_back());
    while (q_b.size() > 0 && q_b[$].due > cyc) void'(q_b.pop_back());
    set_in(1'b0, 0, 0, 0, 0);
    reset = 1'b1;
    regs_a = '{default: 0};
    regs_b = '{default: 0};
    pend_b.delete();
    tick();
    reset = 1'b0;
  endtask

  task automatic drain();
    idle(5);
    check("A_queue_drained", q_a.size(), 0);
    check("B_queue_drained", q_b.size(), 0);
    apply_b(cyc);
  endtask

  task automatic dbg_chk(input string nm, input int addr, input int ea, input int eb);
    bus_a.dbg_addr = AW'(addr);
    bus_b.dbg_addr = AW'(addr);
    tick();
    check({"A_", nm}, bus_a.dbg_data, ea);
    check({"B_", nm}, bus_b.dbg_data, eb);
  endtask

  function automatic int pick();
    return ($urandom_range(0, 3) != 0) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 15));
  endfunction

  exp_t ma, mb;

  always @(negedge clk) begin
    if (q_a.size() > 0 && q_a[0].due < cyc) begin
      check("A_missing_result", 0, 1);
      void'(q_a.pop_front());
    end
    if (bus_a.res_valid !== 1'b0) begin
      if (q_a.size() == 0 || q_a[0].due != cyc) check("A_unexpected_valid", 32'(bus_a.res_valid), 0);
      else begin
        ma = q_a.pop_front();
        check("A_result", {bus_a.res_dst, bus_a.res_data, bus_a.res_zero, bus_a.res_carry, bus_a.res_illegal}, ma.v);
      end
    end
  end

  always @(negedge clk) begin
    if (q_b.size() > 0 && q_b[0].due < cyc) begin
      check("B_missing_result", 0, 1);
      void'(q_b.pop_front());
    end
    if (bus_b.res_valid !== 1'b0) begin
      if (q_b.size() == 0 || q_b[0].due != cyc) check("B_unexpected_valid", 32'(bus_b.res_valid), 0);
      else begin
        mb = q_b.pop_front();
        check("B_result", {bus_b.res_dst, bus_b.res_data, bus_b.res_zero, bus_b.res_carry, bus_b.res_illegal}, mb.v);
      end
    end
  end

  initial begin
    reset = 1'b1;
    set_in(1'b0, 0, 0, 0, 0);
    bus_a.dbg_addr = '0;
    bus_b.dbg_addr = '0;
    regs_a = '{default: 0};
    regs_b = '{default: 0};
    tick();
    tick();
    reset = 1'b0;
    check("A_reset_valid", 32'(bus_a.res_valid), 0);
    check("B_reset_valid", 32'(bus_b.res_valid), 0);
    for (int i = 0; i < 16; i++) dbg_chk("reset_regfile", i, 0, 0);

    // Back-to-back dependent INCs: bypassed 1,2,3 versus stale 1,1,1.
    issue(0, 1, 1, 1);
    issue(0, 1, 1, 1);
    issue(0, 1, 1, 1);
    drain();
    dbg_chk("inc_chain_r1", 1, 3, 1);

    // NOT then one bubble then ADD: write-first capture in S2.
    issue(2, 0, 0, 2);
    idle(1);
    issue(5, 2, 2, 3);
    drain();
    dbg_chk("not_r2", 2, 63, 63);
    dbg_chk("add_bypass_r3", 3, 62, 0);

    issue(0, 2, 2, 4);
    drain();
    dbg_chk("inc_overflow_r4", 4, 0, 63);

    issue(14, 1, 1, 5);
    issue(0, 6, 6, 6);
    drain();
    dbg_chk("illegal_r5", 5, 0, 0);
    dbg_chk("after_illegal_r6", 6, 1, 1);

    // Reset with instructions in flight.
    issue(0, 7, 7, 7);
    issue(0, 7, 7, 7);
    issue(0, 7, 7, 7);
    do_reset();
    for (int k = 0; k < 4; k++) begin
      check("A_post_reset_valid", 32'(bus_a.res_valid), 0);
      check("B_post_reset_valid", 32'(bus_b.res_valid), 0);
      tick();
    end
    for (int i = 0; i < 16; i++) dbg_chk("post_reset_regfile", i, 0, 0);

    // Random traffic with hazard-heavy register choice, bubbles and occasional resets.
    for (int n = 0; n < 800; n++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 2) do_reset();
      else if (r < 15) idle(1);
      else issue(int'($urandom_range(0, 15)), pick(), pick(), pick());
    end
    drain();
    for (int i = 0; i < 16; i++) dbg_chk("final_regfile", i, regs_a[i], regs_b[i]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
